// File: rtl/axi_10g_ethernet_0_link_ctrl_if.sv
// axi_10g_ethernet_0_link_ctrl_if: pause request stream toward the MAC
interface axi_10g_ethernet_0_link_ctrl_if;
    logic [15:0] s_axis_pause_tdata;
    logic        s_axis_pause_tvalid;
    modport master(output s_axis_pause_tdata, s_axis_pause_tvalid);
    modport slave(input s_axis_pause_tdata, s_axis_pause_tvalid);
endinterface

// File: rtl/axi_10g_ethernet_0_link_ctrl.sv
// axi_10g_ethernet_0_link_ctrl: 10G link bring-up/teardown sequencer with hysteretic pause generation
module axi_10g_ethernet_0_link_ctrl #(
    parameter int          STABLE_CYCLES = 1024,
    parameter int          LOCK_TIMEOUT  = 1048576,
    parameter int          RESET_PULSE   = 64,
    parameter int          MAX_FRAME     = 1518,
    parameter logic [15:0] PAUSE_QUANTA  = 16'hFFFF,
    parameter int          PAUSE_REFRESH = 32768,
    parameter int          LEVEL_W       = 12
) (
    input  logic                coreclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic                jumbo_en,
    input  logic [47:0]         pause_src_addr,
    input  logic                resetdone,
    input  logic                qplllock,
    input  logic [7:0]          pcspma_status,
    input  logic [2:0]          mac_status_vector,
    input  logic [LEVEL_W-1:0]  rx_fill_level,
    input  logic [LEVEL_W-1:0]  xoff_thresh,
    input  logic [LEVEL_W-1:0]  xon_thresh,
    output logic [79:0]         mac_tx_configuration_vector,
    output logic [79:0]         mac_rx_configuration_vector,
    output logic                tx_axis_aresetn,
    output logic                rx_axis_aresetn,
    output logic                core_reset_req,
    output logic                link_up,
    output logic [2:0]          state_out,
    axi_10g_ethernet_0_link_ctrl_if.master pause
);
    localparam int CMAX = STABLE_CYCLES > RESET_PULSE ? STABLE_CYCLES : RESET_PULSE;
    localparam int CW   = $clog2(CMAX > 16 ? CMAX : 16);
    localparam int TW   = $clog2(LOCK_TIMEOUT);
    localparam int RW   = $clog2(PAUSE_REFRESH);
    typedef enum logic [2:0] {IDLE, WAIT_LOCK, WAIT_BLOCK, STABLE, RELEASE, UP, DOWN, CORE_RST} state_t;
    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tmo;
    logic [RW-1:0]   rcnt;
    logic            en_q, jumbo_q, xoff_active;
    logic [47:0]     addr_q;
    logic            blk, lf, good, fall, tmo_exp;
    logic            link_d, tx_en_d, rx_en_d, axis_d, latch;
    logic            run, hi, lo, xoff_send, xon_send;
    logic            unused_status;
    assign unused_status = ^{pcspma_status[7:1], mac_status_vector[2]};
    assign blk     = pcspma_status[0];
    assign lf      = mac_status_vector[0];
    assign good    = blk & ~lf & ~mac_status_vector[1];
    assign fall    = en_q & ~enable;
    assign tmo_exp = tmo == TW'(LOCK_TIMEOUT - 1);
    always_comb begin
        state_d = state;
        case (state)
            IDLE:       state_d = enable ? WAIT_LOCK : IDLE;
            WAIT_LOCK:  state_d = (qplllock & resetdone) ? WAIT_BLOCK : tmo_exp ? CORE_RST : WAIT_LOCK;
            WAIT_BLOCK: state_d = good ? STABLE : tmo_exp ? CORE_RST : WAIT_BLOCK;
            STABLE:     state_d = !good ? WAIT_BLOCK : cnt == CW'(STABLE_CYCLES - 1) ? RELEASE : STABLE;
            RELEASE:    state_d = cnt == CW'(15) ? UP : RELEASE;
            UP:         state_d = (!blk || lf || !enable) ? DOWN : UP;
            DOWN:       state_d = cnt == CW'(7) ? (enable ? WAIT_BLOCK : IDLE) : DOWN;
            default:    state_d = cnt == CW'(RESET_PULSE - 1) ? WAIT_LOCK : CORE_RST;
        endcase
        if (fall && state != UP && state != CORE_RST) state_d = IDLE;
    end
    // RX enable trails TX by one cycle on teardown; AXIS resets reassert on the 4th DOWN cycle
    always_comb begin
        link_d  = state_d == UP;
        tx_en_d = state_d == UP;
        rx_en_d = state_d == UP || (state == UP && state_d == DOWN);
        axis_d  = state_d == RELEASE || state_d == UP || (state_d == DOWN && (state == UP || cnt < CW'(3)));
        latch   = state_d == WAIT_LOCK && state != WAIT_LOCK;
        run       = state == UP && state_d == UP;
        hi        = rx_fill_level >= xoff_thresh;
        lo        = rx_fill_level <= xon_thresh;
        xoff_send = run && !pause.s_axis_pause_tvalid && ((hi && !xoff_active) || (xoff_active && rcnt == '0));
        xon_send  = run && !pause.s_axis_pause_tvalid && !xoff_send && xoff_active && lo && !hi;
    end
    always_ff @(posedge coreclk or negedge aresetn) begin
        if (!aresetn) begin
            state                       <= IDLE;
            cnt                         <= '0;
            tmo                         <= '0;
            en_q                        <= 1'b0;
            jumbo_q                     <= 1'b0;
            addr_q                      <= '0;
            state_out                   <= '0;
            link_up                     <= 1'b0;
            tx_axis_aresetn             <= 1'b0;
            rx_axis_aresetn             <= 1'b0;
            core_reset_req              <= 1'b0;
            mac_tx_configuration_vector <= '0;
            mac_rx_configuration_vector <= '0;
        end else begin
            state                       <= state_d;
            cnt                         <= state_d != state ? '0 : cnt + CW'(1);
            tmo                         <= (state == WAIT_LOCK || state == WAIT_BLOCK) ? tmo + TW'(1) : state == STABLE ? tmo : '0;
            en_q                        <= enable;
            jumbo_q                     <= latch ? jumbo_en : jumbo_q;
            addr_q                      <= latch ? pause_src_addr : addr_q;
            state_out                   <= state_d;
            link_up                     <= link_d;
            tx_axis_aresetn             <= axis_d;
            rx_axis_aresetn             <= axis_d;
            core_reset_req              <= state_d == CORE_RST;
            mac_tx_configuration_vector <= {addr_q, 1'b0, 15'(MAX_FRAME), 1'b0, ~jumbo_q, 8'b0, 1'b1, jumbo_q, 2'b0, tx_en_d, 1'b0};
            mac_rx_configuration_vector <= {48'b0, 1'b0, 15'(MAX_FRAME), 1'b0, ~jumbo_q, 8'b0, 1'b1, jumbo_q, 2'b0, rx_en_d, 1'b0};
        end
    end
    always_ff @(posedge coreclk or negedge aresetn) begin
        if (!aresetn) begin
            xoff_active               <= 1'b0;
            rcnt                      <= '0;
            pause.s_axis_pause_tvalid <= 1'b0;
            pause.s_axis_pause_tdata  <= '0;
        end else begin
            xoff_active               <= run && (xoff_send || (xoff_active && !xon_send));
            rcnt                      <= !run ? '0 : xoff_send ? RW'(PAUSE_REFRESH - 1) : rcnt != '0 ? rcnt - RW'(1) : '0;
            pause.s_axis_pause_tvalid <= xoff_send || xon_send;
            pause.s_axis_pause_tdata  <= xoff_send ? PAUSE_QUANTA : xon_send ? 16'h0 : pause.s_axis_pause_tdata;
        end
    end
endmodule

// File: tb/tb_axi_10g_ethernet_0_link_ctrl.sv
// tb_axi_10g_ethernet_0_link_ctrl: directed bring-up, teardown, timeout, pause and async-reset checks
module tb_axi_10g_ethernet_0_link_ctrl;
    logic        coreclk, aresetn, enable, jumbo_en, resetdone, qplllock;
    logic [47:0] pause_src_addr;
    logic [7:0]  pcspma_status;
    logic [2:0]  mac_status_vector;
    logic [11:0] rx_fill_level, xoff_thresh, xon_thresh;
    logic [79:0] tx_cfg, rx_cfg;
    logic        tx_axis_aresetn, rx_axis_aresetn, core_reset_req, link_up;
    logic [2:0]  state_out;
    int          checks, failures, n, first;
    axi_10g_ethernet_0_link_ctrl_if pause();
    axi_10g_ethernet_0_link_ctrl #(.STABLE_CYCLES(16), .LOCK_TIMEOUT(100), .RESET_PULSE(64), .MAX_FRAME(1518),
        .PAUSE_QUANTA(16'hFFFF), .PAUSE_REFRESH(50), .LEVEL_W(12)) dut (
        .coreclk(coreclk), .aresetn(aresetn), .enable(enable), .jumbo_en(jumbo_en),
        .pause_src_addr(pause_src_addr), .resetdone(resetdone), .qplllock(qplllock),
        .pcspma_status(pcspma_status), .mac_status_vector(mac_status_vector),
        .rx_fill_level(rx_fill_level), .xoff_thresh(xoff_thresh), .xon_thresh(xon_thresh),
        .mac_tx_configuration_vector(tx_cfg), .mac_rx_configuration_vector(rx_cfg),
        .tx_axis_aresetn(tx_axis_aresetn), .rx_axis_aresetn(rx_axis_aresetn),
        .core_reset_req(core_reset_req), .link_up(link_up), .state_out(state_out), .pause(pause.master));
    initial coreclk = 1'b0;
    always #5 coreclk = ~coreclk;
    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge coreclk);
        #1;
    endtask
    task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
        int k;
        k = 0;
        while (state_out !== s && k < lim) begin
            tick;
            k++;
        end
        chk(tag, 80'(state_out), 80'(s));
    endtask
    task automatic count_state(input logic [2:0] s, output int cnt);
        cnt = 0;
        while (state_out === s && cnt < 2000) begin
            tick;
            cnt++;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        checks = 0; failures = 0;
        aresetn = 0; enable = 1; jumbo_en = 0; resetdone = 0; qplllock = 0;
        pause_src_addr = 48'h0A0B0C0D0E0F; pcspma_status = 0; mac_status_vector = 0;
        rx_fill_level = 100; xoff_thresh = 2048; xon_thresh = 512;
        repeat (3) tick;
        chk("rst_state", 80'(state_out), 0);
        chk("rst_link", 80'(link_up), 0);
        chk("rst_axis", 80'({tx_axis_aresetn, rx_axis_aresetn}), 0);
        chk("rst_tx_cfg", tx_cfg, 0);
        chk("rst_rx_cfg", rx_cfg, 0);
        chk("rst_pause", 80'({core_reset_req, pause.s_axis_pause_tvalid, pause.s_axis_pause_tdata}), 0);
        @(negedge coreclk);
        aresetn = 1;
        repeat (5) tick;
        pause_src_addr = 48'hDEADBEEF0001;
        repeat (5) tick;
        qplllock = 1; resetdone = 1;
        repeat (10) tick;
        pcspma_status = 8'h01;
        tick;
        chk("enter_stable", 80'(state_out), 3);
        repeat (3) tick;
        pcspma_status = 8'h00;
        tick;
        chk("glitch_wait_block", 80'(state_out), 2);
        chk("glitch_link", 80'(link_up), 0);
        pcspma_status = 8'h01;
        tick;
        chk("reenter_stable", 80'(state_out), 3);
        count_state(3'd3, n);
        chk("stable_len", 80'(n), 16);
        chk("release_state", 80'(state_out), 4);
        chk("release_axis", 80'({tx_axis_aresetn, rx_axis_aresetn}), 80'(2'b11));
        chk("release_tx_en", 80'(tx_cfg[1]), 0);
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (k == 15) chk("link_early", 80'(link_up), 0);
        end
        chk("link_up", 80'(link_up), 1);
        chk("up_tx_en", 80'(tx_cfg[1]), 1);
        chk("up_rx_en", 80'(rx_cfg[1]), 1);
        chk("up_maxframe", 80'(tx_cfg[30:16]), 1518);
        chk("up_tx_flags", 80'({tx_cfg[14], tx_cfg[5], tx_cfg[4]}), 80'(3'b110));
        chk("up_tx_addr", 80'(tx_cfg[79:32]), 48'h0A0B0C0D0E0F);
        chk("up_rx_addr", 80'(rx_cfg[79:32]), 0);
        chk("up_rx_maxframe", 80'(rx_cfg[30:16]), 1518);
        tick;
        chk("pause_idle", 80'(pause.s_axis_pause_tvalid), 0);
        rx_fill_level = 3000;
        tick;
        chk("xoff_valid", 80'(pause.s_axis_pause_tvalid), 1);
        chk("xoff_data", 80'(pause.s_axis_pause_tdata), 16'hFFFF);
        n = 0; first = 0;
        for (int i = 1; i <= 100; i++) begin
            tick;
            if (pause.s_axis_pause_tvalid) begin
                n++;
                if (first == 0) first = i;
            end
        end
        chk("xoff_refresh_cnt", 80'(n), 2);
        chk("xoff_refresh_gap", 80'(first), 50);
        chk("xoff_refresh_data", 80'(pause.s_axis_pause_tdata), 16'hFFFF);
        repeat (10) tick;
        rx_fill_level = 400;
        tick;
        chk("xon_valid", 80'(pause.s_axis_pause_tvalid), 1);
        chk("xon_data", 80'(pause.s_axis_pause_tdata), 0);
        n = 0;
        repeat (120) begin
            tick;
            n += int'(pause.s_axis_pause_tvalid);
        end
        chk("xon_quiet", 80'(n), 0);
        mac_status_vector = 3'b001;
        tick;
        chk("down_state", 80'(state_out), 6);
        chk("down_tx_en", 80'(tx_cfg[1]), 0);
        chk("down_rx_en_hold", 80'(rx_cfg[1]), 1);
        chk("down_link", 80'(link_up), 0);
        mac_status_vector = 3'b000;
        tick;
        chk("down_rx_en", 80'(rx_cfg[1]), 0);
        repeat (2) tick;
        chk("down_axis_hold", 80'({tx_axis_aresetn, rx_axis_aresetn}), 80'(2'b11));
        tick;
        chk("down_axis_rst", 80'({tx_axis_aresetn, rx_axis_aresetn}), 0);
        repeat (3) tick;
        chk("down_len", 80'(state_out), 6);
        tick;
        chk("down_exit", 80'(state_out), 2);
        wait_state(3'd5, 200, "relink");
        enable = 0;
        tick;
        chk("disable_down", 80'(state_out), 6);
        repeat (8) tick;
        chk("disable_idle", 80'(state_out), 0);
        qplllock = 0; enable = 1;
        tick;
        chk("tmo_wait_lock", 80'(state_out), 1);
        count_state(3'd1, n);
        chk("tmo_len", 80'(n), 100);
        chk("core_rst_state", 80'(state_out), 7);
        n = 0;
        while (core_reset_req === 1'b1 && n < 2000) begin
            tick;
            n++;
        end
        chk("core_rst_len", 80'(n), 64);
        chk("core_rst_exit", 80'(state_out), 1);
        qplllock = 1;
        wait_state(3'd5, 300, "relink_after_rst");
        @(posedge coreclk);
        #3 aresetn = 0;
        #1;
        chk("async_state", 80'(state_out), 0);
        chk("async_link", 80'(link_up), 0);
        chk("async_cfg", tx_cfg | rx_cfg, 0);
        chk("async_axis", 80'({tx_axis_aresetn, rx_axis_aresetn}), 0);
        @(negedge coreclk);
        aresetn = 1;
        tick;
        chk("reseq_wait_lock", 80'(state_out), 1);
        wait_state(3'd5, 300, "reseq_up");
        chk("reseq_link", 80'(link_up), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
